musb_branch_sequencer: RTL and testbench
========================================

Name: musb_branch_sequencer

Overview:
- Owns the fetch PC and sequences control transfers resolved in ID by the branch unit (taken flag plus target address).
- Holds ID while branch operands are not forwarded/ready.
- Buffers a redirect that resolves while IF is stalled; arbitrates branch redirects against exception redirects.
- Sits between the hazard unit, branch unit and instruction-fetch stage. Delay-slot architecture: the instruction in IF when the branch resolves is never flushed.

Parameters:
- PC_RESET, 32'h0000_0000, fetch address loaded on reset.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- if_stall  in  1  IF cannot accept a new PC this cycle (imem wait)
- id_stall  in  1  ID held by a downstream hazard
- id_is_branch  in  1  ID holds a branch/jump (any opcode the branch unit decodes)
- id_operands_ready  in  1  rs/rt values for the ID branch are valid
- id_take_branch  in  1  branch unit decision
- id_branch_address  in  32  branch unit target
- exc_redirect  in  1  exception/ERET redirect request, single-cycle pulse
- exc_address  in  32  exception vector / return address
- if_pc  out  32  current fetch PC
- if_pc_add4  out  32  if_pc + 4
- if_misaligned  out  1  if_pc[1:0] != 0
- id_branch_stall  out  1  request to hazard unit to hold IF/ID
- redirect_valid  out  1  pulse: if_pc was loaded non-sequentially last edge
- stat_branches  out  32  resolved branch count (see Optional Feature)
- stat_taken  out  32  taken branch count (see Optional Feature)

Behaviour:
- Reset (synchronous, rst=1 at edge):
  - if_pc=PC_RESET; state=RUN; pending cleared; redirect_valid=0; stats=0.
  - Outputs valid from the first cycle after reset.
- if_pc_add4 and if_misaligned are combinational from if_pc, 32-bit wrap: 32'hFFFF_FFFC+4 = 0.
- Resolution event res = id_is_branch & id_operands_ready & ~id_stall. Counted exactly once per branch.
- id_branch_stall = id_is_branch & ~id_operands_ready & state!=EXC_PENDING. Combinational, no latency.
- States: RUN, BR_PENDING (taken target buffered), EXC_PENDING (exception target buffered).
- Next-PC priority at each edge:
  1. exc_redirect
  2. buffered pending target
  3. res & id_take_branch target
  4. if_pc+4
- if_stall=0, priority source selected:
  - if_pc <= selected value.
  - Any non-sequential load sets redirect_valid=1 for one cycle.
  - State -> RUN.
- if_stall=1:
  - if_pc held.
  - exc_redirect: latch exc_address, -> EXC_PENDING. Overrides BR_PENDING.
  - Otherwise, in RUN with res & id_take_branch: latch id_branch_address, -> BR_PENDING.
  - Otherwise state and buffer held.
- In EXC_PENDING:
  - Branch resolutions are ignored; stats are not counted.
  - A new exc_redirect replaces the buffer (last wins).
- In BR_PENDING:
  - A second res is impossible by construction (the delay slot cannot resolve before IF advances).
  - If res occurs anyway, it is ignored.
- res & ~id_take_branch: sequential fetch, no state change.
- Target alignment is not checked on load. A misaligned JR target is loaded as-is and flagged on if_misaligned.
- rst mid-pending discards the buffer.

Optional Feature:
- Macro: MUSB_BRANCH_STATS_EN.
- Defined:
  - stat_branches increments on every counted res.
  - stat_taken increments on counted res & id_take_branch.
  - Both wrap modulo 2^32; reset to 0.
- Undefined: both ports tied to 32'h0; no counter flops.

Test Plan:
- Reset with PC_RESET=32'h100, no stalls, 3 cycles -> if_pc 0x100, 0x104, 0x108; redirect_valid=0.
- Taken branch to 0x400, res while if_pc=0x208, if_stall=0 -> next if_pc=0x400, redirect_valid=1 for one cycle; stat_taken=1.
- Taken branch to 0x400 with if_stall=1 for 3 cycles -> if_pc held at 0x208, state BR_PENDING; first cycle after stall drops, if_pc=0x400.
- id_operands_ready=0 for 2 cycles, then 1 with take=0 -> id_branch_stall=1 for exactly 2 cycles; then if_pc+4; stat_branches=1, stat_taken=0.
- Same cycle: exc_redirect to 0x80 and taken branch to 0x400, if_stall=0 -> if_pc=0x80. Repeat with if_stall=1 -> EXC_PENDING, later if_pc=0x80.
- JR target 0x403 -> if_pc=0x403, if_misaligned=1. rst asserted while BR_PENDING -> if_pc=PC_RESET, pending discarded.

Source files
------------

// File: rtl/musb_branch_sequencer.sv
// Fetch-PC owner and control-transfer sequencer for a delay-slot pipeline.
// Optional branch statistics counters are enabled by defining MUSB_BRANCH_STATS_EN.
module musb_branch_sequencer #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_stall,
  input  logic        id_stall,
  input  logic        id_is_branch,
  input  logic        id_operands_ready,
  input  logic        id_take_branch,
  input  logic [31:0] id_branch_address,
  input  logic        exc_redirect,
  input  logic [31:0] exc_address,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_add4,
  output logic        if_misaligned,
  output logic        id_branch_stall,
  output logic        redirect_valid,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_taken
);

  typedef enum logic [1:0] {
    RUN         = 2'd0,
    BR_PENDING  = 2'd1,
    EXC_PENDING = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_pend;
  logic        r_redirect;
  logic [31:0] w_pc_nxt;
  logic [31:0] w_pend_nxt;
  logic        w_redirect_nxt;
  logic [31:0] w_pc_add4;
  logic        w_res;

  assign w_res           = id_is_branch & id_operands_ready & ~id_stall;
  assign w_pc_add4       = r_pc + 32'd4;
  assign if_pc           = r_pc;
  assign if_pc_add4      = w_pc_add4;
  assign if_misaligned   = |r_pc[1:0];
  assign redirect_valid  = r_redirect;
  assign id_branch_stall = id_is_branch & ~id_operands_ready & (r_state != EXC_PENDING);

  // Next-PC priority: exception, buffered target, taken branch, sequential.
  always_comb begin
    w_state_nxt    = r_state;
    w_pend_nxt     = r_pend;
    w_pc_nxt       = r_pc;
    w_redirect_nxt = 1'b0;
    if (!if_stall) begin
      w_state_nxt = RUN;
      if (exc_redirect) begin
        w_pc_nxt       = exc_address;
        w_redirect_nxt = 1'b1;
      end else if (r_state != RUN) begin
        w_pc_nxt       = r_pend;
        w_redirect_nxt = 1'b1;
      end else if (w_res && id_take_branch) begin
        w_pc_nxt       = id_branch_address;
        w_redirect_nxt = 1'b1;
      end else begin
        w_pc_nxt = w_pc_add4;
      end
    end else begin
      // IF cannot take a PC: park the redirect, exceptions overriding branches.
      if (exc_redirect) begin
        w_pend_nxt  = exc_address;
        w_state_nxt = EXC_PENDING;
      end else if ((r_state == RUN) && w_res && id_take_branch) begin
        w_pend_nxt  = id_branch_address;
        w_state_nxt = BR_PENDING;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RUN;
      r_pc       <= PC_RESET;
      r_redirect <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_pc       <= w_pc_nxt;
      r_redirect <= w_redirect_nxt;
    end
  end

  // Buffer is only meaningful while state != RUN, so it needs no reset.
  always_ff @(posedge clk) begin
    r_pend <= w_pend_nxt;
  end

`ifdef MUSB_BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_taken;
  logic        w_count;

  // Only resolutions seen in RUN are real; pending states ignore them.
  assign w_count = w_res & (r_state == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stat_branches <= 32'd0;
      r_stat_taken    <= 32'd0;
    end else if (w_count) begin
      r_stat_branches <= r_stat_branches + 32'd1;
      if (id_take_branch) r_stat_taken <= r_stat_taken + 32'd1;
    end
  end

  assign stat_branches = r_stat_branches;
  assign stat_taken    = r_stat_taken;
`else
  assign stat_branches = 32'h0;
  assign stat_taken    = 32'h0;
`endif

endmodule

// File: tb/tb_musb_branch_sequencer.sv
// Directed self-checking bench for musb_branch_sequencer (PC_RESET = 0x100).
module tb_musb_branch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_stall;
  logic        id_stall;
  logic        id_is_branch;
  logic        id_operands_ready;
  logic        id_take_branch;
  logic [31:0] id_branch_address;
  logic        exc_redirect;
  logic [31:0] exc_address;
  logic [31:0] if_pc;
  logic [31:0] if_pc_add4;
  logic        if_misaligned;
  logic        id_branch_stall;
  logic        redirect_valid;
  logic [31:0] stat_branches;
  logic [31:0] stat_taken;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  musb_branch_sequencer #(.PC_RESET(32'h100)) dut (
    .clk               (clk),
    .rst               (rst),
    .if_stall          (if_stall),
    .id_stall          (id_stall),
    .id_is_branch      (id_is_branch),
    .id_operands_ready (id_operands_ready),
    .id_take_branch    (id_take_branch),
    .id_branch_address (id_branch_address),
    .exc_redirect      (exc_redirect),
    .exc_address       (exc_address),
    .if_pc             (if_pc),
    .if_pc_add4        (if_pc_add4),
    .if_misaligned     (if_misaligned),
    .id_branch_stall   (id_branch_stall),
    .redirect_valid    (redirect_valid),
    .stat_branches     (stat_branches),
    .stat_taken        (stat_taken)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic branch(input logic is_br, input logic rdy, input logic take, input logic [31:0] addr);
    id_is_branch      = is_br;
    id_operands_ready = rdy;
    id_take_branch    = take;
    id_branch_address = addr;
  endtask

  task automatic exc(input logic req, input logic [31:0] addr);
    exc_redirect = req;
    exc_address  = addr;
  endtask

  function automatic logic [31:0] st(input logic [31:0] v);
`ifdef MUSB_BRANCH_STATS_EN
    return v;
`else
    return 32'h0 & v;
`endif
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; if_stall = 1'b0; id_stall = 1'b0;
    branch(0, 0, 0, 32'h0); exc(0, 32'h0);
    step(); step();
    rst = 1'b0;
    chk("reset_pc", if_pc, 32'h100);
    chk("reset_redir", {31'd0, redirect_valid}, 32'd0);
    chk("reset_stat_br", stat_branches, 32'd0);
    chk("reset_stat_tk", stat_taken, 32'd0);
    step(); chk("seq_pc1", if_pc, 32'h104);
    step(); chk("seq_pc2", if_pc, 32'h108);
    chk("seq_add4", if_pc_add4, 32'h10C);
    chk("seq_redir", {31'd0, redirect_valid}, 32'd0);

    // Taken branch, no stall
    exc(1, 32'h208); step(); exc(0, 32'h0);
    chk("exc_pc_208", if_pc, 32'h208);
    chk("exc_redir", {31'd0, redirect_valid}, 32'd1);
    branch(1, 1, 1, 32'h400); step(); branch(0, 0, 0, 32'h0);
    chk("tk_pc", if_pc, 32'h400);
    chk("tk_redir", {31'd0, redirect_valid}, 32'd1);
    chk("tk_stat_tk", stat_taken, st(32'd1));
    chk("tk_stat_br", stat_branches, st(32'd1));
    step();
    chk("tk_pc_next", if_pc, 32'h404);
    chk("tk_redir_drop", {31'd0, redirect_valid}, 32'd0);

    // Taken branch during IF stall is buffered
    exc(1, 32'h208); step(); exc(0, 32'h0);
    if_stall = 1'b1;
    branch(1, 1, 1, 32'h400); step(); branch(0, 0, 0, 32'h0);
    chk("bp_hold1", if_pc, 32'h208);
    chk("bp_redir_hold", {31'd0, redirect_valid}, 32'd0);
    step(); step();
    chk("bp_hold3", if_pc, 32'h208);
    if_stall = 1'b0; step();
    chk("bp_release_pc", if_pc, 32'h400);
    chk("bp_release_redir", {31'd0, redirect_valid}, 32'd1);
    chk("bp_stat_br", stat_branches, st(32'd2));

    // Operands not ready for two cycles, then not-taken
    branch(1, 0, 0, 32'h0); #1;
    chk("ops_stall_c1", {31'd0, id_branch_stall}, 32'd1);
    step(); chk("ops_stall_c2", {31'd0, id_branch_stall}, 32'd1);
    step(); branch(1, 1, 0, 32'h0); #1;
    chk("ops_stall_done", {31'd0, id_branch_stall}, 32'd0);
    chk("ops_pc", if_pc, 32'h408);
    step(); branch(0, 0, 0, 32'h0);
    chk("nt_pc", if_pc, 32'h40C);
    chk("nt_redir", {31'd0, redirect_valid}, 32'd0);
    chk("nt_stat_br", stat_branches, st(32'd3));
    chk("nt_stat_tk", stat_taken, st(32'd2));

    // Exception beats a same-cycle taken branch
    exc(1, 32'h80); branch(1, 1, 1, 32'h400); step();
    chk("exc_prio_pc", if_pc, 32'h80);
    chk("exc_prio_redir", {31'd0, redirect_valid}, 32'd1);
    exc(1, 32'h200); step(); exc(0, 32'h0); branch(0, 0, 0, 32'h0);
    if_stall = 1'b1;
    exc(1, 32'h80); branch(1, 1, 1, 32'h400); step();
    exc(0, 32'h0); branch(1, 0, 0, 32'h0); #1;
    chk("ep_hold", if_pc, 32'h200);
    chk("ep_no_br_stall", {31'd0, id_branch_stall}, 32'd0);
    branch(0, 0, 0, 32'h0);
    step();
    if_stall = 1'b0; step();
    chk("ep_release_pc", if_pc, 32'h80);
    chk("ep_release_redir", {31'd0, redirect_valid}, 32'd1);

    // Last exception wins while pending
    if_stall = 1'b1;
    exc(1, 32'h80); step(); exc(1, 32'h90); step(); exc(0, 32'h0);
    if_stall = 1'b0; step();
    chk("exc_last_wins", if_pc, 32'h90);

    // Misaligned JR target
    branch(1, 1, 1, 32'h403); step(); branch(0, 0, 0, 32'h0);
    chk("mis_pc", if_pc, 32'h403);
    chk("mis_flag", {31'd0, if_misaligned}, 32'd1);
    chk("mis_add4", if_pc_add4, 32'h407);

    // Reset while a branch is pending
    if_stall = 1'b1;
    branch(1, 1, 1, 32'h600); step(); branch(0, 0, 0, 32'h0);
    rst = 1'b1; step(); rst = 1'b0; if_stall = 1'b0;
    chk("rst_pend_pc", if_pc, 32'h100);
    chk("rst_pend_flag", {31'd0, if_misaligned}, 32'd0);
    chk("rst_pend_stat", stat_branches, 32'd0);
    step();
    chk("rst_discard_pc", if_pc, 32'h104);
    chk("rst_discard_redir", {31'd0, redirect_valid}, 32'd0);

    // 32-bit wrap
    exc(1, 32'hFFFF_FFFC); step(); exc(0, 32'h0);
    chk("wrap_add4", if_pc_add4, 32'h0);
    step();
    chk("wrap_pc", if_pc, 32'h0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
